// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding (common to the transmitter),
// default frame width and the legal oversampling ratios.
package uart_pkg;

   localparam int DATA_SIZE_DEF = 8;

   localparam int PRESC_8  = 8;
   localparam int PRESC_16 = 16;
   localparam int PRESC_32 = 32;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_e;

   function automatic logic majority3(input logic [2:0] s);
      return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
   endfunction

endpackage

// File: rtl/uart_rx_fsm_if.sv
// Receive-side output bundle from the UART receiver to the register/FIFO layer.
interface uart_rx_fsm_if #(
   parameter int DATA_SIZE = uart_pkg::DATA_SIZE_DEF
);
   import uart_pkg::*;

   // Data_Valid is a one-cycle strobe with no ready: the consumer must take
   // P_DATA in the strobe cycle. P_DATA and the flags then hold until the next frame.
   logic [DATA_SIZE-1:0] P_DATA;
   logic                 Data_Valid;
   logic                 PAR_ERR;
   logic                 STP_ERR;
   uart_state_e          dbg_state;

   modport master (
      output P_DATA,
      output Data_Valid,
      output PAR_ERR,
      output STP_ERR,
      output dbg_state
   );

   modport slave (
      input P_DATA,
      input Data_Valid,
      input PAR_ERR,
      input STP_ERR,
      input dbg_state
   );

endinterface

// File: rtl/uart_rx_sampler.sv
// Three-tap majority voter: captures the line at mid-bit -1/0/+1 and votes.
module uart_rx_sampler
   import uart_pkg::*;
#(
   parameter int PRESCALE_W = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx_s_i,
   input  logic [PRESCALE_W-1:0] edge_cnt_i,
   input  logic [PRESCALE_W-1:0] presc_i,
   output logic                  sampled_bit_o
);

   localparam logic [PRESCALE_W-1:0] E_ONE = PRESCALE_W'(1);

   logic [PRESCALE_W-1:0] half;
   logic [PRESCALE_W-1:0] mid_lo;
   logic [PRESCALE_W-1:0] mid_hi;
   logic [2:0]            samp_q;

   assign half   = presc_i >> 1;
   assign mid_lo = half - E_ONE;
   assign mid_hi = half + E_ONE;

   // Samples reset to the idle level so a vote is never taken on X.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         samp_q <= 3'b111;
      end else begin
         if (edge_cnt_i == mid_lo) samp_q[0] <= rx_s_i;
         if (edge_cnt_i == half)   samp_q[1] <= rx_s_i;
         if (edge_cnt_i == mid_hi) samp_q[2] <= rx_s_i;
      end
   end

   assign sampled_bit_o = majority3(samp_q);

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receiver: synchronizer, start detection, per-bit majority vote,
// LSB-first assembly, parity/stop checks and registered outputs.
module uart_rx_fsm
   import uart_pkg::*;
#(
   parameter int DATA_SIZE  = DATA_SIZE_DEF,
   parameter int PRESCALE_W = 6
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RX_IN,
   input  logic [PRESCALE_W-1:0] Prescale,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   uart_rx_fsm_if.master         rx_if
);

   localparam int BIT_W = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
   localparam logic [BIT_W-1:0]      LAST_BIT = BIT_W'(DATA_SIZE - 1);
   localparam logic [BIT_W-1:0]      B_ONE    = BIT_W'(1);
   localparam logic [PRESCALE_W-1:0] E_ONE    = PRESCALE_W'(1);

   logic [1:0]            sync_q;
   logic                  rx_s;
   uart_state_e           state_q;
   logic [PRESCALE_W-1:0] edge_cnt_q;
   logic [PRESCALE_W-1:0] edge_cnt_d;
   logic [PRESCALE_W-1:0] presc_q;
   logic [BIT_W-1:0]      bit_cnt_q;
   logic [BIT_W-1:0]      bit_cnt_d;
   logic [DATA_SIZE-1:0]  shift_q;
   logic [DATA_SIZE-1:0]  shift_d;
   logic [DATA_SIZE-1:0]  p_data_q;
   logic                  par_en_q;
   logic                  par_typ_q;
   logic                  valid_q;
   logic                  par_err_q;
   logic                  stp_err_q;
   logic                  sampled_bit;
   logic                  bit_end;
   logic                  par_exp;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) sync_q <= 2'b11;
      else     sync_q <= {sync_q[0], RX_IN};
   end

   assign rx_s = sync_q[1];

   uart_rx_sampler #(
      .PRESCALE_W (PRESCALE_W)
   ) u_sampler (
      .clk           (CLK),
      .rst           (RST),
      .rx_s_i        (rx_s),
      .edge_cnt_i    (edge_cnt_q),
      .presc_i       (presc_q),
      .sampled_bit_o (sampled_bit)
   );

   assign edge_cnt_d = edge_cnt_q + E_ONE;
   assign bit_cnt_d  = bit_cnt_q + B_ONE;
   assign bit_end    = (edge_cnt_q == presc_q - E_ONE);
   assign shift_d    = {sampled_bit, shift_q[DATA_SIZE-1:1]};
   assign par_exp    = (^shift_q) ^ par_typ_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= IDLE;
         edge_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         presc_q    <= PRESCALE_W'(PRESC_8);
         par_en_q   <= 1'b0;
         par_typ_q  <= 1'b0;
         p_data_q   <= '0;
         valid_q    <= 1'b0;
         par_err_q  <= 1'b0;
         stp_err_q  <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         if (state_q != IDLE) edge_cnt_q <= bit_end ? '0 : edge_cnt_d;
         case (state_q)
            IDLE: begin
               // The detection clock is edge 0 of the start bit, so count resumes at 1.
               if (!rx_s) begin
                  state_q    <= START;
                  edge_cnt_q <= E_ONE;
                  bit_cnt_q  <= '0;
                  presc_q    <= Prescale;
                  par_en_q   <= PAR_EN;
                  par_typ_q  <= PAR_TYP;
                  par_err_q  <= 1'b0;
                  stp_err_q  <= 1'b0;
               end
            end
            START: begin
               if (bit_end) state_q <= sampled_bit ? IDLE : DATA;
            end
            DATA: begin
               if (bit_end) begin
                  shift_q <= shift_d;
                  if (bit_cnt_q == LAST_BIT) begin
                     bit_cnt_q <= '0;
                     state_q   <= par_en_q ? PARITY : STOP;
                  end else begin
                     bit_cnt_q <= bit_cnt_d;
                  end
               end
            end
            PARITY: begin
               if (bit_end) begin
                  par_err_q <= (sampled_bit != par_exp);
                  state_q   <= STOP;
               end
            end
            STOP: begin
               if (bit_end) begin
                  stp_err_q <= ~sampled_bit;
                  if (!par_err_q && sampled_bit) begin
                     p_data_q <= shift_q;
                     valid_q  <= 1'b1;
                  end
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rx_if.P_DATA     = p_data_q;
   assign rx_if.Data_Valid = valid_q;
   assign rx_if.PAR_ERR    = par_err_q;
   assign rx_if.STP_ERR    = stp_err_q;
   assign rx_if.dbg_state  = state_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm: frames are built from bit lists, good frames are
// queued with their due cycle, and a monitor checks every Data_Valid strobe.
module tb_uart_rx_fsm;
   import uart_pkg::*;

   logic       clk      = 1'b0;
   logic       rst      = 1'b1;
   logic       rx_in    = 1'b1;
   logic [5:0] prescale = 6'd8;
   logic       par_en   = 1'b0;
   logic       par_typ  = 1'b0;

   uart_rx_fsm_if #(.DATA_SIZE(8)) rx_if ();

   uart_rx_fsm #(
      .DATA_SIZE  (8),
      .PRESCALE_W (6)
   ) dut (
      .CLK      (clk),
      .RST      (rst),
      .RX_IN    (rx_in),
      .Prescale (prescale),
      .PAR_EN   (par_en),
      .PAR_TYP  (par_typ),
      .rx_if    (rx_if)
   );

   // ---------------- clock / cycle count ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard ----------------
   logic [7:0] exp_q[$];
   int         due_q[$];
   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] model_pdata   = 8'h00;
   logic       model_par_err = 1'b0;
   logic       model_stp_err = 1'b0;
   logic       prev_valid    = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      logic [7:0] e;
      int         d;
      if (rst) begin
         prev_valid = 1'b0;
      end else begin
         if (rx_if.Data_Valid) begin
            check("valid_width", {31'd0, prev_valid}, 32'd0);
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_valid: P_DATA=0x%0h with no frame pending (cycle %0d)",
                        rx_if.P_DATA, cyc);
            end else begin
               e = exp_q.pop_front();
               d = due_q.pop_front();
               check("p_data", {24'd0, rx_if.P_DATA}, {24'd0, e});
               check("valid_cycle", cyc, d);
               check("flags_on_valid", {30'd0, rx_if.PAR_ERR, rx_if.STP_ERR}, 32'd0);
            end
         end else if (due_q.size() > 0 && cyc > due_q[0]) begin
            n_tests++;
            n_fail++;
            $display("FAIL missing_valid: expected 0x%0h at cycle %0d, still absent at cycle %0d",
                     exp_q[0], due_q[0], cyc);
            void'(exp_q.pop_front());
            void'(due_q.pop_front());
         end
         prev_valid = rx_if.Data_Valid;
      end
   end

   // ---------------- driver tasks (all start and end on a negedge) ----------------
   function automatic logic [5:0] rand_p();
      case ($urandom_range(0, 2))
         0:       return 6'(PRESC_8);
         1:       return 6'(PRESC_16);
         default: return 6'(PRESC_32);
      endcase
   endfunction

   task automatic send_frame(input logic [7:0] data, input int p, input bit pen, input bit ptyp,
                             input bit par_ok, input bit stop_bit, input bit scramble);
      logic bits[$];
      int   c0;
      int   nbits;
      logic good_par;
      good_par = (^data) ^ ptyp;
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(data[i]);
      if (pen) bits.push_back(par_ok ? good_par : ~good_par);
      bits.push_back(stop_bit);
      nbits    = bits.size();
      prescale = 6'(p);
      par_en   = pen;
      par_typ  = ptyp;
      c0       = cyc;
      for (int b = 0; b < nbits; b++) begin
         rx_in = bits[b];
         repeat (p) @(negedge clk);
         if (b == 0 && scramble) begin
            prescale = rand_p();
            par_en   = 1'($urandom_range(0, 1));
            par_typ  = 1'($urandom_range(0, 1));
         end
      end
      rx_in = 1'b1;
      // Two synchronizer clocks separate the line edge from detection.
      model_par_err = pen && !par_ok;
      model_stp_err = !stop_bit;
      if (stop_bit && (!pen || par_ok)) begin
         exp_q.push_back(data);
         due_q.push_back(c0 + 2 + nbits * p);
         model_pdata = data;
      end
   endtask

   task automatic check_idle(input string tag);
      repeat (4) @(negedge clk);
      check({tag, "_par_err"}, {31'd0, rx_if.PAR_ERR}, {31'd0, model_par_err});
      check({tag, "_stp_err"}, {31'd0, rx_if.STP_ERR}, {31'd0, model_stp_err});
      check({tag, "_p_data"},  {24'd0, rx_if.P_DATA},  {24'd0, model_pdata});
   endtask

   // ---------------- stimulus ----------------
   initial begin
      repeat (3) @(negedge clk);
      check("rst_p_data",  {24'd0, rx_if.P_DATA},     32'd0);
      check("rst_valid",   {31'd0, rx_if.Data_Valid}, 32'd0);
      check("rst_par_err", {31'd0, rx_if.PAR_ERR},    32'd0);
      check("rst_stp_err", {31'd0, rx_if.STP_ERR},    32'd0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // Even parity, valid at detection + 88.
      send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      check_idle("a5");

      // Back-to-back frames at Prescale 16.
      send_frame(8'h3C, 16, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      send_frame(8'hFF, 16, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      check_idle("b2b");

      // Odd parity with the parity bit inverted.
      send_frame(8'h01, 8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      check_idle("par_err");

      // Stop bit low, then a good frame clears the flag.
      send_frame(8'h55, 32, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      check_idle("stp_err");
      send_frame(8'h12, 32, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      check_idle("after_stp");

      // Three-clock start glitch.
      prescale = 6'd16;
      par_en   = 1'b0;
      rx_in    = 1'b0;
      repeat (3) @(negedge clk);
      rx_in = 1'b1;
      repeat (26) @(negedge clk);
      check_idle("glitch");
      send_frame(8'h81, 16, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      check_idle("after_glitch");

      // Break: line low through the stop bit, then straight into the next start.
      send_frame(8'h00, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      send_frame(8'h3A, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      check_idle("break");

      // Randomized frames with mid-frame config changes and random spacing.
      for (int n = 0; n < 16; n++) begin
         send_frame(8'($urandom_range(0, 255)), int'(rand_p()), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 4) != 0),
                    ($urandom_range(0, 5) != 0), 1'b1);
         if (n == 15 || $urandom_range(0, 2) != 0) begin
            check_idle("rand");
            repeat ($urandom_range(0, 5)) @(negedge clk);
         end
      end

      // Reset in the middle of data bit 4.
      send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      check_idle("pre_rst");
      prescale = 6'd16;
      par_en   = 1'b0;
      rx_in    = 1'b0;
      repeat (16) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rx_in = i[0];
         repeat (16) @(negedge clk);
      end
      rx_in = 1'b1;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_p_data",  {24'd0, rx_if.P_DATA},     32'd0);
      check("midrst_valid",   {31'd0, rx_if.Data_Valid}, 32'd0);
      check("midrst_par_err", {31'd0, rx_if.PAR_ERR},    32'd0);
      check("midrst_stp_err", {31'd0, rx_if.STP_ERR},    32'd0);
      check("midrst_state",   {29'd0, rx_if.dbg_state},  {29'd0, IDLE});
      model_pdata   = 8'h00;
      model_par_err = 1'b0;
      model_stp_err = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      send_frame(8'h7E, 16, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      check_idle("after_rst");

      repeat (50) @(negedge clk);
      check("queue_drained", exp_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Watchdog.
   initial begin
      #500000;
      n_fail++;
      $display("FAIL watchdog: simulation did not complete by cycle %0d", cyc);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
